seq_shifter: RTL and testbench
==============================

# seq_shifter

Multi-cycle variable-amount shifter for the IJVM shift instructions (ISHL, ISHR, IUSHR). It sits beside the fixed datapath shifter and complements it with the opposite primitives: logical right-by-byte and left-by-one-bit. It adds arithmetic/logical variants of both directions, driven iteratively by a small state machine. The microsequencer issues a start pulse with operand and amount, stalls on busy, and takes the result to the C bus when done pulses.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of 8.
- AMT_W, 5: shift-amount width; only amounts 0..WIDTH-1 are legal.
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dir  input  1  0 = left, 1 = right
- arith  input  1  1 = sign-fill on right shifts; ignored for left shifts, which always zero-fill
- amount  input  AMT_W  shift distance
- in  input  WIDTH  operand
- busy  output  1  high while a shift is in progress
- done  output  1  one-cycle pulse; out is valid in this cycle
- out  output  WIDTH  result register

## Operation
- State machine states and transitions:
  - IDLE, start=1: latch in, dir, arith and amount into working register acc and counter rem.
    - rem>=8 -> BYTE
    - 0<rem<8 -> BIT
    - rem=0 -> DONE
  - BYTE: acc shifts 8 bits per cycle in the latched direction; rem -= 8.
    - Stay in BYTE while the new rem>=8; else go to BIT if rem>0, else DONE.
  - BIT: acc shifts 1 bit per cycle; rem -= 1; go to DONE when the new rem=0.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Fill rules:
  - Left: zeros enter at the LSBs.
  - Right logical: zeros enter at the MSBs.
  - Right arithmetic: copies of acc[WIDTH-1] enter. The sign bit is preserved through every step, so the fill equals the original operand's sign.
- out is driven by acc.
  - Undefined for the consumer while busy.
  - Holds the last result from DONE until the next accepted start.
- start outside IDLE (BYTE, BIT, DONE) is ignored; there is no queueing.
- Illegal amount (>= WIDTH, only possible when 2^AMT_W > WIDTH) saturates to an all-fill result: 0, or all-ones for a negative arithmetic right shift.

## Timing
- Cycle 0: start accepted in IDLE.
- Latency from start to the done cycle: 1 + floor(amount/8) + (amount mod 8).
  - amount=0 -> done at cycle 1.
  - amount=31 -> done at cycle 11.
- busy: high from cycle 1 through the last BYTE/BIT cycle; low in DONE and IDLE.
  - busy and done are never high together.
- Back-to-back: a start asserted in the DONE cycle is ignored. The earliest accepted start is the cycle after done.
- Reset values:
  - State IDLE, acc=0, rem=0.
  - out=0, busy=0, done=0.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. The in-flight shift is discarded and no done is produced.

## Configuration
- SEQ_SHIFTER_BYTE_STEP_EN defined:
  - BYTE state is present.
  - Latency as stated in Timing.
- SEQ_SHIFTER_BYTE_STEP_EN undefined:
  - BYTE state is removed; every shift uses BIT steps only.
  - Latency = 1 + amount.
  - Results are bit-identical to the defined case.

## Structure
- Package seq_shifter_pkg holds:
  - the state enum (IDLE, BYTE, BIT, DONE)
  - BYTE_STEP = 8
  - default WIDTH and AMT_W constants
- Sub-module shift_step: purely combinational single step.
  - Inputs: acc, dir, arith, byte_mode.
  - Output: acc shifted by 8 or by 1 with the correct fill.
  - The FSM instantiates it once and selects byte_mode from the state.

## Test plan
- Left, in=0x000000FF, amount=12 -> out=0x000FF000, done at cycle 6 (cycle 13 with macro off).
- Right arithmetic, in=0x80000000, amount=31 -> out=0xFFFFFFFF, done at cycle 11.
- Right logical, in=0x80000000, amount=31 -> out=0x00000001, done at cycle 11.
- amount=0, in=0xDEADBEEF, dir=1, arith=1 -> out=0xDEADBEEF, done at cycle 1; busy never asserted.
- Second start (in=0x1, amount=1) at cycles 2 and 3 of a 12-bit left shift -> ignored; the original result is unchanged.
  - A start in the cycle after done is accepted.
- reset at cycle 3 of a 31-bit shift:
  - Next cycle: out=0, busy=0, done=0.
  - No done pulse follows.
  - A fresh start then completes normally.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// -----------------------------------------------------------------------------
// seq_shifter_pkg
// Shared definitions for the sequential IJVM shifter: FSM state encoding,
// the byte step distance and the default operand / amount widths.
// -----------------------------------------------------------------------------
package seq_shifter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BYTE = 2'd1,
        BIT  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int BYTE_STEP     = 8;
    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_AMT_W = 5;

endpackage

// File: rtl/seq_shifter_step.sv
// -----------------------------------------------------------------------------
// shift_step
// Purely combinational single shift step used by the seq_shifter FSM.
// Shifts acc by BYTE_STEP bits (byte_mode=1) or by one bit (byte_mode=0).
//
// Ports:
//   acc       in  WIDTH  current working value
//   dir       in  1      0 = left, 1 = right
//   arith     in  1      1 = sign fill on right shifts (ignored for left)
//   byte_mode in  1      1 = shift by BYTE_STEP, 0 = shift by 1
//   acc_next  out WIDTH  shifted value
// -----------------------------------------------------------------------------
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic             dir,
    input  logic             arith,
    input  logic             byte_mode,
    output logic [WIDTH-1:0] acc_next
);

    logic fill;

    always_comb begin
        // Left shifts always zero-fill; right shifts fill with the current
        // MSB only when arithmetic, which keeps the original sign in place.
        fill     = dir & arith & acc[WIDTH-1];
        acc_next = acc;
        if (!dir) begin
            if (byte_mode) begin
                acc_next = {acc[WIDTH-BYTE_STEP-1:0], {BYTE_STEP{1'b0}}};
            end else begin
                acc_next = {acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (byte_mode) begin
                acc_next = {{BYTE_STEP{fill}}, acc[WIDTH-1:BYTE_STEP]};
            end else begin
                acc_next = {fill, acc[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
// Multi-cycle variable-amount shifter for ISHL / ISHR / IUSHR. A start pulse
// in IDLE latches the operand and amount; the FSM then shifts by whole bytes
// (BYTE state) and single bits (BIT state) until the remaining distance is
// zero, and pulses done for one cycle with the result on out.
//
// Build option:
//   SEQ_SHIFTER_BYTE_STEP_EN  defined   -> byte steps used for amount >= 8
//                             undefined -> bit steps only (latency 1+amount)
//
// Ports:
//   clk     in  1      rising-edge clock
//   reset   in  1      synchronous active-high reset
//   start   in  1      request, sampled only in IDLE
//   dir     in  1      0 = left, 1 = right
//   arith   in  1      1 = sign fill on right shifts
//   amount  in  AMT_W  shift distance (>= WIDTH saturates to all-fill)
//   in      in  WIDTH  operand
//   busy    out 1      shift in progress (BYTE/BIT states)
//   done    out 1      one-cycle result-valid pulse
//   out     out WIDTH  result register; holds until next accepted start
// -----------------------------------------------------------------------------
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int AMT_W = DEFAULT_AMT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             dir,
    input  logic             arith,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

`ifdef SEQ_SHIFTER_BYTE_STEP_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             dir_q, dir_d;
    logic             arith_q, arith_d;
    logic [WIDTH-1:0] step_acc;

    // Amounts at or beyond the operand width shift everything out.
    function automatic logic amount_illegal(input logic [AMT_W-1:0] amt);
        return 32'(amt) >= 32'(WIDTH);
    endfunction

    // Saturated result for an out-of-range amount: the fill value everywhere.
    function automatic logic [WIDTH-1:0] sat_fill(input logic [WIDTH-1:0] op,
                                                  input logic             d,
                                                  input logic             a);
        logic signed [WIDTH-1:0] op_s;
        op_s = op;
        if (d && a) begin
            return $unsigned(op_s >>> (WIDTH - 1));
        end
        return '0;
    endfunction

    // Next working state for a given remaining distance.
    function automatic state_e step_state(input logic [AMT_W-1:0] r);
        if (r == '0) begin
            return DONE;
        end
        if (BYTE_EN && (32'(r) >= 32'(BYTE_STEP))) begin
            return BYTE;
        end
        return BIT;
    endfunction

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc       (acc_q),
        .dir       (dir_q),
        .arith     (arith_q),
        .byte_mode (state_q == BYTE),
        .acc_next  (step_acc)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d   = dir;
                    arith_d = arith;
                    if (amount_illegal(amount)) begin
                        acc_d   = sat_fill(in, dir, arith);
                        rem_d   = '0;
                        state_d = DONE;
                    end else begin
                        acc_d   = in;
                        rem_d   = amount;
                        state_d = step_state(amount);
                    end
                end
            end
            BYTE: begin
                acc_d   = step_acc;
                rem_d   = rem_q - AMT_W'(BYTE_STEP);
                state_d = step_state(rem_d);
            end
            BIT: begin
                acc_d   = step_acc;
                rem_d   = rem_q - AMT_W'(1);
                state_d = step_state(rem_d);
            end
            DONE: begin
                // Any start seen here is dropped; the FSM only listens in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
        end
    end

    assign busy = (state_q == BYTE) || (state_q == BIT);
    assign done = (state_q == DONE);
    assign out  = acc_q;

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
// Directed-vector bench for seq_shifter (WIDTH=32, AMT_W=5). Each vector
// carries hand-computed result and latency for both build options.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

`ifdef SEQ_SHIFTER_BYTE_STEP_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        dir;
    logic        arith;
    logic [4:0]  amount;
    logic [31:0] in;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int nvec = 0;
    int nerr = 0;

    seq_shifter #(
        .WIDTH (32),
        .AMT_W (5)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dir    (dir),
        .arith  (arith),
        .amount (amount),
        .in     (in),
        .busy   (busy),
        .done   (done),
        .out    (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one shift and follow it to done. ign_a / ign_b name cycles (1 =
    // first cycle after acceptance) in which a stray start is driven.
    task automatic run_shift(input string tag, input logic [31:0] op, input logic d,
                             input logic a, input logic [4:0] amt,
                             input logic [31:0] exp_out, input int lat_b,
                             input int lat_s, input int ign_a, input int ign_b);
        int   exp_lat;
        int   cyc;
        int   busy_cnt;
        logic got;
        logic both;
        exp_lat  = BYTE_EN ? lat_b : lat_s;
        @(negedge clk);
        in     = op;
        dir    = d;
        arith  = a;
        amount = amt;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        both     = 1'b0;
        while (!got && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cyc == ign_a || cyc == ign_b) begin
                in     = 32'h0000_0001;
                amount = 5'd1;
                dir    = 1'b0;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (busy && done) both = 1'b1;
            if (done) got = 1'b1;
        end
        chk({tag, ":done_seen"}, 32'(got), 32'd1);
        chk({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
        chk({tag, ":busy_and_done"}, 32'(both), 32'd0);
        chk({tag, ":out"}, out, exp_out);
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, ":out_hold"}, out, exp_out);
        chk({tag, ":done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        reset  = 1'b1;
        start  = 1'b0;
        dir    = 1'b0;
        arith  = 1'b0;
        amount = 5'd0;
        in     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset:out", out, 32'h0);
        chk("reset:busy", 32'(busy), 32'd0);
        chk("reset:done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Stray starts in cycles 2 and 3 of a 12-bit left shift are ignored.
        run_shift("shl12_stray", 32'h0000_00FF, 1'b0, 1'b0, 5'd12, 32'h000F_F000, 6, 13, 2, 3);
        // Accepted right after done; a stray start in its own done cycle is dropped.
        run_shift("shl1_b2b", 32'h0000_0001, 1'b0, 1'b0, 5'd1, 32'h0000_0002, 2, 2, 2, 0);
        run_shift("sar31", 32'h8000_0000, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFF, 11, 32, 0, 0);
        run_shift("shr31", 32'h8000_0000, 1'b1, 1'b0, 5'd31, 32'h0000_0001, 11, 32, 0, 0);
        run_shift("amt0", 32'hDEAD_BEEF, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 1, 1, 0, 0);
        run_shift("sar9_pos", 32'h7FFF_FFF0, 1'b1, 1'b1, 5'd9, 32'h003F_FFFF, 3, 10, 0, 0);
        run_shift("sar4_neg", 32'hF000_0000, 1'b1, 1'b1, 5'd4, 32'hFF00_0000, 5, 5, 0, 0);
        run_shift("shl16", 32'h1234_5678, 1'b0, 1'b0, 5'd16, 32'h5678_0000, 3, 17, 0, 0);
        run_shift("shl1_arith", 32'h8000_0001, 1'b0, 1'b1, 5'd1, 32'h0000_0002, 2, 2, 0, 0);
        run_shift("sar8", 32'h8000_1234, 1'b1, 1'b1, 5'd8, 32'hFF80_0012, 2, 9, 0, 0);
        run_shift("shr15", 32'hF0F0_F0F0, 1'b1, 1'b0, 5'd15, 32'h0001_E1E1, 9, 16, 0, 0);

        // Reset in cycle 3 of a 31-bit arithmetic right shift.
        @(negedge clk);
        in     = 32'h8000_0000;
        dir    = 1'b1;
        arith  = 1'b1;
        amount = 5'd31;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midreset:busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset:out", out, 32'h0);
        chk("midreset:busy", 32'(busy), 32'd0);
        chk("midreset:done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dcnt  = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midreset:no_done", 32'(dcnt), 32'd0);
        run_shift("after_reset", 32'h0000_000F, 1'b0, 1'b0, 5'd28, 32'hF000_0000, 8, 29, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
